// File: rtl/register_file_pkg.sv
// register_file_pkg: shared width defaults and the hardwired-zero register index
package register_file_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int REG_ZERO   = 0;
endpackage

// File: rtl/register_file_write_decoder.sv
// regfile_write_decoder: one-hot write select gated by write enable; index 0 never selected
module regfile_write_decoder
    import register_file_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                 i_wr_en,
    input  logic [ADDR_W-1:0]    i_wr_addr,
    output logic [2**ADDR_W-1:0] o_sel
);
    always_comb begin
        o_sel = '0;
        o_sel[i_wr_addr] = i_wr_en;
        o_sel[REG_ZERO] = 1'b0;
    end
endmodule

// File: rtl/register_file.sv
// register_file: 2**ADDR_W x DATA_W register file, two combinational read ports with
// write-to-read bypass, register 0 hardwired to zero, flag for attempted writes to it
module register_file
    import register_file_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              zero_wr_attempt
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] r_regs [DEPTH];
    logic              r_zero_wr;
    logic [DEPTH-1:0]  w_sel;
    logic              w_wr_zero;
    logic              w_wr_live;

    regfile_write_decoder #(.ADDR_W(ADDR_W)) u_dec (
        .i_wr_en   (wr_en),
        .i_wr_addr (wr_addr),
        .o_sel     (w_sel)
    );

    assign w_wr_zero = wr_en && (wr_addr == ZERO_IDX);
    assign w_wr_live = wr_en && (wr_addr != ZERO_IDX);

    // Entry 0 is cleared by reset and never selected, so it stays zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
            r_zero_wr <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) if (w_sel[i]) r_regs[i] <= wr_data;
            r_zero_wr <= w_wr_zero;
        end
    end

    assign rd_data_a = (reset || rd_addr_a == ZERO_IDX) ? '0 :
                       (w_wr_live && wr_addr == rd_addr_a) ? wr_data : r_regs[rd_addr_a];
    assign rd_data_b = (reset || rd_addr_b == ZERO_IDX) ? '0 :
                       (w_wr_live && wr_addr == rd_addr_b) ? wr_data : r_regs[rd_addr_b];
    assign zero_wr_attempt = r_zero_wr;
endmodule
